// File: rtl/ei_axi4_pkg.sv
// rtl/ei_axi4_pkg.sv - shared AXI4 checker types, error bit indices and attribute check helper
package ei_axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED    = 2'b00,
    BURST_INCR     = 2'b01,
    BURST_WRAP     = 2'b10,
    BURST_RSVD_ENC = 2'b11
  } burst_type_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } response_e;

  localparam int NUM_ERR = 14;

  typedef enum int {
    ERR_AW_UNSTABLE    = 0,
    ERR_W_UNSTABLE     = 1,
    ERR_B_UNSTABLE     = 2,
    ERR_AR_UNSTABLE    = 3,
    ERR_R_UNSTABLE     = 4,
    ERR_WLAST_MISMATCH = 5,
    ERR_RLAST_MISMATCH = 6,
    ERR_W_NO_AW        = 7,
    ERR_B_UNEXPECTED   = 8,
    ERR_R_UNEXPECTED   = 9,
    ERR_OVERFLOW       = 10,
    ERR_BURST_RSVD     = 11,
    ERR_WRAP_LEN       = 12,
    ERR_SIZE           = 13
  } chk_err_e;

  // Returns {size, wrap_len, burst_rsvd} violations for one address beat.
  function automatic logic [2:0] attr_check(input logic [1:0] burst, input logic [7:0] len,
                                            input logic [2:0] size, input logic [2:0] max_size);
    logic [2:0] e;
    e    = '0;
    e[0] = (burst == BURST_RSVD_ENC);
    e[1] = (burst == BURST_WRAP) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    e[2] = (size > max_size);
    return e;
  endfunction

endpackage

// File: rtl/ei_axi4_len_fifo.sv
// rtl/ei_axi4_len_fifo.sv - burst-length FIFO with occupancy count and empty-FIFO bypass head
module ei_axi4_len_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [7:0]             push_len,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic                   head_valid,
  output logic [7:0]             head_len,
  output logic                   overflow
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          bypass;
  logic          wr_en;
  logic          rd_en;

  assign empty      = (count == '0);
  assign full       = (count == (PW + 1)'(DEPTH));
  assign head_valid = !empty || push;
  assign head_len   = empty ? push_len : mem[rd_ptr];
  // A push consumed in the same cycle by a pop on an empty FIFO never gets stored.
  assign bypass     = empty && push && pop;
  assign wr_en      = push && !bypass && (!full || pop);
  assign rd_en      = pop && !empty;
  assign overflow   = push && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_len;
  end

endmodule

// File: rtl/ei_axi4_protocol_checker.sv
// rtl/ei_axi4_protocol_checker.sv - passive AXI4 protocol checker and burst tracker
module ei_axi4_protocol_checker
  import ei_axi4_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [ADDR_WIDTH-1:0]             awaddr,
  input  logic [7:0]                        awlen,
  input  logic [2:0]                        awsize,
  input  logic [1:0]                        awburst,
  input  logic                              awvalid,
  input  logic                              awready,
  input  logic [DATA_WIDTH-1:0]             wdata,
  input  logic [DATA_WIDTH/8-1:0]           wstrb,
  input  logic                              wlast,
  input  logic                              wvalid,
  input  logic                              wready,
  input  logic [1:0]                        bresp,
  input  logic                              bvalid,
  input  logic                              bready,
  input  logic [ADDR_WIDTH-1:0]             araddr,
  input  logic [7:0]                        arlen,
  input  logic [2:0]                        arsize,
  input  logic [1:0]                        arburst,
  input  logic                              arvalid,
  input  logic                              arready,
  input  logic [DATA_WIDTH-1:0]             rdata,
  input  logic [1:0]                        rresp,
  input  logic                              rlast,
  input  logic                              rvalid,
  input  logic                              rready,
  output logic [NUM_ERR-1:0]                err_pulse,
  output logic [NUM_ERR-1:0]                err_sticky,
  output logic [$clog2(MAX_OUTSTANDING):0]  wr_outstanding,
  output logic [$clog2(MAX_OUTSTANDING):0]  rd_outstanding,
  output logic [CNT_WIDTH-1:0]              wr_done_cnt,
  output logic [CNT_WIDTH-1:0]              rd_done_cnt
);
  localparam int         OW       = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));
  localparam int         AXW      = ADDR_WIDTH + 13;
  localparam int         WW       = DATA_WIDTH + DATA_WIDTH / 8 + 1;
  localparam int         RW       = DATA_WIDTH + 3;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;
  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  // Payload snapshots for the stall-stability compares
  logic [AXW-1:0] aw_pl, aw_pl_q, ar_pl, ar_pl_q;
  logic [WW-1:0]  w_pl, w_pl_q;
  logic [RW-1:0]  r_pl, r_pl_q;
  logic [1:0]     b_pl_q;
  logic           aw_stall_q, w_stall_q, b_stall_q, ar_stall_q, r_stall_q;

  assign aw_pl = {awaddr, awlen, awsize, awburst};
  assign ar_pl = {araddr, arlen, arsize, arburst};
  assign w_pl  = {wdata, wstrb, wlast};
  assign r_pl  = {rdata, rresp, rlast};

  logic [OW-1:0] b_pend;
  logic [7:0]    w_beat, r_beat;

  logic       w_head_valid, r_head_valid, w_ovf, r_ovf;
  logic [7:0] w_head_len, r_head_len;
  logic       w_active, r_active, w_last_exp, r_last_exp, w_pop, r_pop, b_ok;
  logic [2:0] aw_attr, ar_attr;

  assign w_active   = w_hs && w_head_valid;
  assign r_active   = r_hs && r_head_valid;
  assign w_last_exp = (w_beat == w_head_len);
  assign r_last_exp = (r_beat == r_head_len);
  assign w_pop      = w_active && (wlast || w_last_exp);
  assign r_pop      = r_active && (rlast || r_last_exp);
  assign b_ok       = b_hs && (b_pend != '0);
  assign aw_attr    = aw_hs ? attr_check(awburst, awlen, awsize, MAX_SIZE) : 3'b000;
  assign ar_attr    = ar_hs ? attr_check(arburst, arlen, arsize, MAX_SIZE) : 3'b000;

  ei_axi4_len_fifo #(.DEPTH(MAX_OUTSTANDING)) u_wr_fifo (
    .clk(aclk), .rst_n(aresetn), .push(aw_hs), .push_len(awlen), .pop(w_pop),
    .count(wr_outstanding), .head_valid(w_head_valid), .head_len(w_head_len), .overflow(w_ovf)
  );

  ei_axi4_len_fifo #(.DEPTH(MAX_OUTSTANDING)) u_rd_fifo (
    .clk(aclk), .rst_n(aresetn), .push(ar_hs), .push_len(arlen), .pop(r_pop),
    .count(rd_outstanding), .head_valid(r_head_valid), .head_len(r_head_len), .overflow(r_ovf)
  );

  logic [NUM_ERR-1:0] err_comb;

  always_comb begin
    err_comb                     = '0;
    err_comb[ERR_AW_UNSTABLE]    = aw_stall_q && (!awvalid || aw_pl != aw_pl_q);
    err_comb[ERR_W_UNSTABLE]     = w_stall_q && (!wvalid || w_pl != w_pl_q);
    err_comb[ERR_B_UNSTABLE]     = b_stall_q && (!bvalid || bresp != b_pl_q);
    err_comb[ERR_AR_UNSTABLE]    = ar_stall_q && (!arvalid || ar_pl != ar_pl_q);
    err_comb[ERR_R_UNSTABLE]     = r_stall_q && (!rvalid || r_pl != r_pl_q);
    err_comb[ERR_WLAST_MISMATCH] = w_active && (wlast != w_last_exp);
    err_comb[ERR_RLAST_MISMATCH] = r_active && (rlast != r_last_exp);
    err_comb[ERR_W_NO_AW]        = w_hs && !w_head_valid;
    err_comb[ERR_B_UNEXPECTED]   = b_hs && (b_pend == '0);
    err_comb[ERR_R_UNEXPECTED]   = r_hs && !r_head_valid;
    err_comb[ERR_OVERFLOW]       = w_ovf || r_ovf;
    err_comb[ERR_BURST_RSVD]     = aw_attr[0] || ar_attr[0];
    err_comb[ERR_WRAP_LEN]       = aw_attr[1] || ar_attr[1];
    err_comb[ERR_SIZE]           = aw_attr[2] || ar_attr[2];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_stall_q  <= 1'b0;
      w_stall_q   <= 1'b0;
      b_stall_q   <= 1'b0;
      ar_stall_q  <= 1'b0;
      r_stall_q   <= 1'b0;
      aw_pl_q     <= '0;
      w_pl_q      <= '0;
      b_pl_q      <= '0;
      ar_pl_q     <= '0;
      r_pl_q      <= '0;
      w_beat      <= '0;
      r_beat      <= '0;
      b_pend      <= '0;
      wr_done_cnt <= '0;
      rd_done_cnt <= '0;
      err_pulse   <= '0;
      err_sticky  <= '0;
    end else begin
      aw_stall_q <= awvalid && !awready;
      w_stall_q  <= wvalid && !wready;
      b_stall_q  <= bvalid && !bready;
      ar_stall_q <= arvalid && !arready;
      r_stall_q  <= rvalid && !rready;
      aw_pl_q    <= aw_pl;
      w_pl_q     <= w_pl;
      b_pl_q     <= bresp;
      ar_pl_q    <= ar_pl;
      r_pl_q     <= r_pl;

      if (w_pop)         w_beat <= '0;
      else if (w_active) w_beat <= w_beat + 1'b1;
      if (r_pop)         r_beat <= '0;
      else if (r_active) r_beat <= r_beat + 1'b1;

      // B-pending uses the pre-edge count, so a same-cycle final W cannot cover its own B.
      case ({w_pop, b_ok})
        2'b10:   if (b_pend != OW'(MAX_OUTSTANDING)) b_pend <= b_pend + 1'b1;
        2'b01:   b_pend <= b_pend - 1'b1;
        default: b_pend <= b_pend;
      endcase

      if (b_ok && wr_done_cnt != '1)  wr_done_cnt <= wr_done_cnt + 1'b1;
      if (r_pop && rd_done_cnt != '1) rd_done_cnt <= rd_done_cnt + 1'b1;

      err_pulse  <= err_comb;
      err_sticky <= err_sticky | err_comb;
    end
  end

endmodule
